// File: rtl/pwm_pkg.sv
// pwm_pkg: shared constants and types for the PWM peripheral.
//   - pwm_reg_e      : word-register offsets selected by cpu_addr[3:2]
//   - CTRL_*_BIT     : bit positions inside the CTRL register
//   - PWM_BASE_ADDR  : base of the PWM window (0x0710..0x071F), shared with
//                      the system bus decoder
//   - pwm_ctrl_t     : packed view of the CTRL register as it reads back
package pwm_pkg;

  typedef enum logic [1:0] {
    REG_CTRL   = 2'd0,
    REG_PERIOD = 2'd1,
    REG_DUTY   = 2'd2,
    REG_COUNT  = 2'd3
  } pwm_reg_e;

  localparam int CTRL_EN_BIT       = 0;
  localparam int CTRL_POL_BIT      = 1;
  localparam int CTRL_IRQ_EN_BIT   = 2;
  localparam int CTRL_IRQ_STAT_BIT = 3;

  localparam logic [31:0] PWM_BASE_ADDR = 32'h0000_0710;

  // Field order matches the CTRL bit indices (en is bit 0).
  typedef struct packed {
    logic irq_stat;
    logic irq_en;
    logic pol;
    logic en;
  } pwm_ctrl_t;

endpackage

// File: rtl/pwm_slave_if.sv
// pwm_slave_if: single-cycle CPU bus between the bus master and the PWM
// responder.
//   sel      : slave select from the bus decoder (bSel[3])
//   we       : 1 = write, 0 = read
//   cpu_addr : byte address, only [3:2] decoded by the PWM block
//   wdata    : write data
//   rdata    : registered read data, valid one cycle after a read
// Handshake: there is no ready/wait signal. Every cycle with sel=1 is a
// complete transfer; a write lands on that clock edge and read data is
// presented on rdata from the following edge until the next read.
interface pwm_slave_if;
  logic        sel;
  logic        we;
  logic [31:0] cpu_addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output sel, we, cpu_addr, wdata, input rdata);
  modport slave  (input sel, we, cpu_addr, wdata, output rdata);
endinterface

// File: rtl/pwm_counter.sv
// pwm_counter: period counter, wrap detect, active period/duty shadow
// registers and the duty compare for the PWM peripheral.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : CTRL.EN
//   pol        : CTRL.POL, inverts the output
//   per_s      : staging period from the register file
//   duty_s     : staging duty from the register file
//   count      : live counter value (COUNT register)
//   wrap       : high in the cycle the counter returns to 0 (EN=1 only)
//   pwm_out    : registered PWM output, lags the counter state by one cycle
module pwm_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             pol,
  input  logic [CNT_W-1:0] per_s,
  input  logic [CNT_W-1:0] duty_s,
  output logic [CNT_W-1:0] count,
  output logic             wrap,
  output logic             pwm_out
);

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] per_a_q, per_a_d;
  logic [CNT_W-1:0] duty_a_q, duty_a_d;
  logic             pwm_q, pwm_d;

  always_comb begin
    wrap     = en && (count_q == per_a_q);
    count_d  = count_q;
    per_a_d  = per_a_q;
    duty_a_d = duty_a_q;

    // Active values only change on a period boundary, or freely while
    // disabled, so a running waveform never sees a half-applied update.
    if (!en || wrap) begin
      per_a_d  = per_s;
      duty_a_d = duty_s;
      count_d  = '0;
    end else begin
      count_d  = count_q + CNT_W'(1);
    end

    // duty_a > per_a never fails the compare, giving 100% duty.
    pwm_d = (en && (count_q < duty_a_q)) ^ pol;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      per_a_q  <= '0;
      duty_a_q <= '0;
      pwm_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      per_a_q  <= per_a_d;
      duty_a_q <= duty_a_d;
      pwm_q    <= pwm_d;
    end
  end

  assign count   = count_q;
  assign pwm_out = pwm_q;

endmodule

// File: rtl/pwm_slave.sv
// pwm_slave: bus responder for the PWM peripheral (PWM window 0x0710..0x071F).
// Holds CTRL / PERIOD / DUTY / COUNT and drives one PWM output.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : pwm_slave_if.slave (sel, we, cpu_addr, wdata, rdata)
//   pwm_out    : registered PWM output, equals POL while disabled
//   irq        : registered period-wrap interrupt
// Build option: PWM_IRQ_EN. When defined, CTRL.IRQ_EN / CTRL.IRQ_STAT exist
// and irq = IRQ_STAT & IRQ_EN. When undefined, both bits read 0 and irq is 0.
module pwm_slave
  import pwm_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  pwm_slave_if.slave  bus,
  output logic        pwm_out,
  output logic        irq
);

  logic             en_q, en_d;
  logic             pol_q, pol_d;
  logic [CNT_W-1:0] per_s_q, per_s_d;
  logic [CNT_W-1:0] duty_s_q, duty_s_d;
  logic [31:0]      rdata_q, rdata_d;

  logic             wr, rd;
  pwm_reg_e         reg_sel;
  logic [CNT_W-1:0] count;
  logic             wrap;
  pwm_ctrl_t        ctrl_view;

`ifdef PWM_IRQ_EN
  logic irq_en_q, irq_en_d;
  logic irq_stat_q, irq_stat_d;
  logic irq_q, irq_d;
`endif

  assign wr      = bus.sel && bus.we;
  assign rd      = bus.sel && !bus.we;
  assign reg_sel = pwm_reg_e'(bus.cpu_addr[3:2]);

  pwm_counter #(.CNT_W(CNT_W)) u_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en_q),
    .pol     (pol_q),
    .per_s   (per_s_q),
    .duty_s  (duty_s_q),
    .count   (count),
    .wrap    (wrap),
    .pwm_out (pwm_out)
  );

  always_comb begin
    ctrl_view     = '0;
    ctrl_view.en  = en_q;
    ctrl_view.pol = pol_q;
`ifdef PWM_IRQ_EN
    ctrl_view.irq_en   = irq_en_q;
    ctrl_view.irq_stat = irq_stat_q;
`endif
  end

  always_comb begin
    en_d     = en_q;
    pol_d    = pol_q;
    per_s_d  = per_s_q;
    duty_s_d = duty_s_q;
`ifdef PWM_IRQ_EN
    irq_en_d   = irq_en_q;
    irq_stat_d = irq_stat_q;
`endif

    if (wr) begin
      case (reg_sel)
        REG_CTRL: begin
          en_d  = bus.wdata[CTRL_EN_BIT];
          pol_d = bus.wdata[CTRL_POL_BIT];
`ifdef PWM_IRQ_EN
          irq_en_d = bus.wdata[CTRL_IRQ_EN_BIT];
          if (bus.wdata[CTRL_IRQ_STAT_BIT]) irq_stat_d = 1'b0;
`endif
        end
        REG_PERIOD: per_s_d  = bus.wdata[CNT_W-1:0];
        REG_DUTY:   duty_s_d = bus.wdata[CNT_W-1:0];
        REG_COUNT:  ;
      endcase
    end

`ifdef PWM_IRQ_EN
    // Applied after the clear so a wrap in the same cycle wins.
    if (wrap) irq_stat_d = 1'b1;
    irq_d = irq_stat_q && irq_en_q;
`endif

    rdata_d = rdata_q;
    if (rd) begin
      case (reg_sel)
        REG_CTRL:   rdata_d = 32'(ctrl_view);
        REG_PERIOD: rdata_d = 32'(per_s_q);
        REG_DUTY:   rdata_d = 32'(duty_s_q);
        REG_COUNT:  rdata_d = 32'(count);
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q     <= 1'b0;
      pol_q    <= 1'b0;
      per_s_q  <= '0;
      duty_s_q <= '0;
      rdata_q  <= '0;
    end else begin
      en_q     <= en_d;
      pol_q    <= pol_d;
      per_s_q  <= per_s_d;
      duty_s_q <= duty_s_d;
      rdata_q  <= rdata_d;
    end
  end

`ifdef PWM_IRQ_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_en_q   <= 1'b0;
      irq_stat_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      irq_en_q   <= irq_en_d;
      irq_stat_q <= irq_stat_d;
      irq_q      <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  assign bus.rdata = rdata_q;

  // Address bits outside [3:2], upper write-data bits and (without the
  // interrupt option) the wrap strobe have no function here.
  logic unused_bits;
`ifdef PWM_IRQ_EN
  assign unused_bits = ^{bus.cpu_addr[31:4], bus.cpu_addr[1:0], bus.wdata};
`else
  assign unused_bits = ^{bus.cpu_addr[31:4], bus.cpu_addr[1:0], bus.wdata, wrap};
`endif

endmodule

// File: tb/tb_pwm_slave.sv
// tb_pwm_slave: self-checking bench for pwm_slave (CNT_W = 16).
// Build with PWM_IRQ_EN defined to exercise the interrupt path.
module tb_pwm_slave;
  import pwm_pkg::*;

  localparam int CNT_W = 16;
  localparam logic [31:0] A_CTRL   = PWM_BASE_ADDR + 32'h0;
  localparam logic [31:0] A_PERIOD = PWM_BASE_ADDR + 32'h4;
  localparam logic [31:0] A_DUTY   = PWM_BASE_ADDR + 32'h8;
  localparam logic [31:0] A_COUNT  = PWM_BASE_ADDR + 32'hC;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pwm_out;
  logic irq;

  pwm_slave_if bus();

  pwm_slave #(.CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .pwm_out (pwm_out),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int en_cyc = 0;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // Both tasks return at the falling edge right after the transfer's clock edge.
  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.sel = 1'b1; bus.we = 1'b1; bus.cpu_addr = addr; bus.wdata = data;
    @(negedge clk);
    bus.sel = 1'b0; bus.we = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr);
    @(negedge clk);
    bus.sel = 1'b1; bus.we = 1'b0; bus.cpu_addr = addr;
    @(negedge clk);
    bus.sel = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] exp;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (pwm_out !== 1'b0) begin errors++; $display("FAIL reset_pwm got %b exp 0", pwm_out); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", irq); end
    checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", bus.rdata); end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(32'h0);
      bus_read(PWM_BASE_ADDR + 32'(4 * i));
      exp = exp_q.pop_front();
      checks++; if (bus.rdata !== exp) begin errors++; $display("FAIL reset_read%0d got %h exp %h", i, bus.rdata, exp); end
    end
    checks++; if (pwm_out !== 1'b0) begin errors++; $display("FAIL reset_pwm_after got %b exp 0", pwm_out); end
  endtask

  // PERIOD=9, DUTY=3, enable; COUNT is read every cycle back to back.
  task automatic test_basic();
    int k;
    logic [31:0] exp;
    logic exp_pwm;
    bus_write(A_PERIOD, 32'd9);
    bus_write(A_DUTY, 32'd3);
    bus_write(A_CTRL, 32'h1);
    en_cyc = cyc;
    bus.cpu_addr = A_COUNT; bus.we = 1'b0; bus.sel = 1'b1;
    for (int i = 0; i < 30; i++) begin
      exp_q.push_back(32'((cyc - en_cyc) % 10));
      @(negedge clk);
      k = cyc - en_cyc;
      exp = exp_q.pop_front();
      checks++; if (bus.rdata !== exp) begin errors++; $display("FAIL basic_count k=%0d got %0d exp %0d", k, bus.rdata, exp); end
      exp_pwm = ((k - 1) % 10) < 3;
      checks++; if (pwm_out !== exp_pwm) begin errors++; $display("FAIL basic_pwm k=%0d got %b exp %b", k, pwm_out, exp_pwm); end
    end
    bus.sel = 1'b0;
  endtask

  // DUTY 3 -> 7 written mid-period; the new duty starts at the next wrap.
  task automatic test_duty_change();
    int k, kw, kwrap, d;
    logic exp_pwm;
    repeat (3) @(negedge clk);
    bus_write(A_DUTY, 32'd7);
    kw = cyc - en_cyc;
    kwrap = (kw / 10 + 1) * 10;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      k = cyc - en_cyc;
      d = (k - 1 >= kwrap) ? 7 : 3;
      exp_pwm = ((k - 1) % 10) < d;
      checks++; if (pwm_out !== exp_pwm) begin errors++; $display("FAIL duty_change k=%0d got %b exp %b", k, pwm_out, exp_pwm); end
    end
  endtask

  // DUTY=0 -> constant low, DUTY=12 (> period) -> constant high, POL inverts.
  task automatic test_duty_extremes();
    int k;
    logic [31:0] exp;
    logic exp_pwm;
    bus_write(A_DUTY, 32'd0);
    repeat (12) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if (pwm_out !== 1'b0) begin errors++; $display("FAIL duty_zero got %b exp 0", pwm_out); end
    end
    // Upper bits must be dropped.
    bus_write(A_DUTY, 32'hFFFF_000C);
    exp_q.push_back(32'h0000_000C);
    bus_read(A_DUTY);
    exp = exp_q.pop_front();
    checks++; if (bus.rdata !== exp) begin errors++; $display("FAIL duty_truncate got %h exp %h", bus.rdata, exp); end
    repeat (12) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if (pwm_out !== 1'b1) begin errors++; $display("FAIL duty_full got %b exp 1", pwm_out); end
    end
    bus_write(A_DUTY, 32'd3);
    repeat (12) @(negedge clk);
    bus_write(A_CTRL, 32'h3);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      k = cyc - en_cyc;
      exp_pwm = !(((k - 1) % 10) < 3);
      checks++; if (pwm_out !== exp_pwm) begin errors++; $display("FAIL pol_invert k=%0d got %b exp %b", k, pwm_out, exp_pwm); end
    end
    exp_q.push_back(32'h3);
    bus_read(A_CTRL);
    exp = exp_q.pop_front();
    checks++; if (bus.rdata !== exp) begin errors++; $display("FAIL ctrl_read got %h exp %h", bus.rdata, exp); end
  endtask

  task automatic test_irq();
    logic [31:0] exp;
    logic exp_irq;
    int k;
`ifdef PWM_IRQ_EN
    bus_write(A_CTRL, 32'h0);
    bus_write(A_CTRL, 32'h8);
    bus_write(A_PERIOD, 32'd4);
    bus_write(A_CTRL, 32'h5);
    en_cyc = cyc;
    // First wrap lands on edge 5, irq follows one edge later.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      k = cyc - en_cyc;
      exp_irq = (k >= 6);
      checks++; if (irq !== exp_irq) begin errors++; $display("FAIL irq_first k=%0d got %b exp %b", k, irq, exp_irq); end
    end
    // Clear landing one edge after a wrap.
    for (int i = 0; i < 5 && (((cyc - en_cyc) + 2) % 5 != 1); i++) @(negedge clk);
    bus_write(A_CTRL, 32'hD);
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      exp_irq = (j == 5);
      checks++; if (irq !== exp_irq) begin errors++; $display("FAIL irq_clear j=%0d got %b exp %b", j, irq, exp_irq); end
    end
    // Clear landing on a wrap edge: the set wins.
    for (int i = 0; i < 5 && (((cyc - en_cyc) + 2) % 5 != 0); i++) @(negedge clk);
    bus_write(A_CTRL, 32'hD);
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set_wins j=%0d got %b exp 1", j, irq); end
    end
    exp_q.push_back(32'hD);
`else
    bus_write(A_CTRL, 32'hD);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_tied got %b exp 0", irq); end
    end
    exp_q.push_back(32'h1);
`endif
    bus_read(A_CTRL);
    exp = exp_q.pop_front();
    checks++; if (bus.rdata !== exp) begin errors++; $display("FAIL irq_ctrl_read got %h exp %h", bus.rdata, exp); end
  endtask

  // Reset asserted mid-period at count=5 with POL=1 (output high there).
  task automatic test_reset_mid();
    logic [31:0] exp;
    bus_write(A_CTRL, 32'h0);
    bus_write(A_PERIOD, 32'd9);
    bus_write(A_DUTY, 32'd3);
    bus_write(A_CTRL, 32'h3);
    en_cyc = cyc;
    for (int i = 0; i < 12 && ((cyc - en_cyc) % 10 != 5); i++) @(negedge clk);
    checks++; if (pwm_out !== 1'b1) begin errors++; $display("FAIL pre_reset_pwm got %b exp 1", pwm_out); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (pwm_out !== 1'b0) begin errors++; $display("FAIL async_reset_pwm got %b exp 0", pwm_out); end
    checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL async_reset_rdata got %h exp 0", bus.rdata); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL async_reset_irq got %b exp 0", irq); end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(32'h0);
    bus_read(A_CTRL);
    exp = exp_q.pop_front();
    checks++; if (bus.rdata !== exp) begin errors++; $display("FAIL post_reset_ctrl got %h exp %h", bus.rdata, exp); end
    exp_q.push_back(32'h0);
    bus_read(A_COUNT);
    exp = exp_q.pop_front();
    checks++; if (bus.rdata !== exp) begin errors++; $display("FAIL post_reset_count got %h exp %h", bus.rdata, exp); end
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      checks++; if (pwm_out !== 1'b0) begin errors++; $display("FAIL post_reset_pwm got %b exp 0", pwm_out); end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    bus.sel = 1'b0;
    bus.we = 1'b0;
    bus.cpu_addr = 32'h0;
    bus.wdata = 32'h0;
    test_reset();
    test_basic();
    test_duty_change();
    test_duty_extremes();
    test_irq();
    test_reset_mid();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d entries exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_slave.md
# pwm_slave

Bus responder for the PWM peripheral. It sits behind the system bus decoder on the PWM select line (bSel[3]). It accepts single-cycle CPU reads and writes to four word registers and generates one pulse-width-modulated output. Period and duty updates are double-buffered so that a change always lands on a period boundary.

## Interface
- CNT_W, 16: counter, period and duty width (2..32)
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- sel  in  1  slave select from the bus decoder (bSel[3])
- we  in  1  write strobe; 1 = write, 0 = read
- cpu_addr  in  32  byte address; only [3:2] are used here
- wdata  in  32  write data
- rdata  out  32  registered read data
- pwm_out  out  1  PWM output
- irq  out  1  period-wrap interrupt (constant 0 when PWM_IRQ_EN is undefined)

## Operation
- The decoder's PWM window is 0x0710–0x071F: one word at 0x0710 plus three more word offsets.
- Register map, selected by cpu_addr[3:2]:
  - 0x0 CTRL: bit0 EN, bit1 POL (invert output), bit2 IRQ_EN, bit3 IRQ_STAT (write 1 to clear).
  - 0x4 PERIOD: staging value.
  - 0x8 DUTY: staging value.
  - 0xC COUNT: read-only, live counter value.
- Write: when sel=1 and we=1, the addressed register updates on the clock edge. Writes to COUNT are ignored. Bits at or above CNT_W are dropped on write and read back as 0.
- Read: when sel=1 and we=0, rdata is loaded on the clock edge with the addressed value, zero-extended to 32 bits. Otherwise rdata holds its previous value.
- Active registers per_a and duty_a are copied from staging:
  - when the counter wraps (count == per_a while EN=1), or
  - every cycle while EN=0.
- Counter behaviour:
  - EN=0: count is held at 0.
  - EN=1: count steps 0 → per_a, then wraps to 0. The period is therefore per_a+1 cycles.
- Raw output level is high when count < duty_a, so:
  - duty_a = 0 gives 0% duty (always low).
  - duty_a > per_a gives 100% duty (always high).
  - per_a = 0 makes count stay at 0; the output is high if and only if duty_a != 0.
- pwm_out = (EN & raw) ^ POL, registered. With EN=0, pwm_out equals POL.
- Simultaneous events:
  - A staging write in the same cycle as a wrap: the active copy takes the old staging value; the new value is applied at the next wrap.
  - A wrap and an IRQ_STAT clear in the same cycle: the set wins.

## Timing
- Reset values: rdata=0, pwm_out=0, irq=0. All registers are 0; the counter is 0.
- Read latency is 1 cycle. Back-to-back accesses are allowed every cycle; there are no wait states.
- A write to CTRL.EN takes effect on the next edge. The counter leaves 0 one cycle after EN is seen high.
- pwm_out lags the counter state by one cycle (registered output).
- Asserting rst_n low mid-period clears everything immediately (asynchronously). After release, the block restarts disabled.

## Configuration
- PWM_IRQ_EN defined:
  - IRQ_STAT is set on each wrap.
  - irq = IRQ_STAT & IRQ_EN, registered.
- PWM_IRQ_EN undefined:
  - IRQ_EN and IRQ_STAT are not implemented and read as 0.
  - irq is tied to 0.

## Structure
- pwm_pkg holds:
  - register offset constants (CTRL=2'd0, PERIOD=2'd1, DUTY=2'd2, COUNT=2'd3);
  - CTRL bit-index constants;
  - the PWM base-address constant 0x0710, shared with the decoder.
- One sub-module, pwm_counter: counter, wrap detect, active-register shadowing and the compare logic. The register file and bus handling stay at the top level.

## Test plan
- Reset, then read all four registers → rdata=0 for each, one cycle after the read; pwm_out=0, irq=0.
- Write PERIOD=9, DUTY=3, CTRL=0x1 → pwm_out repeats 3 cycles high, 7 cycles low; COUNT reads cycle through 0..9.
- Running at PERIOD=9/DUTY=3, write DUTY=7 mid-period → the current period stays 3/10; the next period is 7/10 and has no glitch.
- Drive DUTY=0, then DUTY=12 with PERIOD=9, then set CTRL=0x3 (POL=1) → output is constant low, then constant high, then inverted waveform.
- With PWM_IRQ_EN defined, CTRL=0x5 and PERIOD=4 → irq rises one cycle after the first wrap; writing CTRL=0xD clears it; irq re-asserts at the next wrap.
- Assert rst_n mid-period at count=5 → pwm_out=0 and COUNT=0 immediately; after release CTRL reads 0 and the output stays low.
